// File: rtl/demo_sysid_pkg.sv
// Shared definitions for the system-ID register block: word offsets, CAPS layout
// and the byte-lane merge used for SCRATCH writes.
package demo_sysid_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
    localparam logic [2:0] ADDR_CAPS      = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;
    localparam logic [2:0] ADDR_RSVD      = 3'd7;

    localparam int unsigned CAPS_UPTIME_BIT  = 0;
    localparam int unsigned CAPS_VERSION_LSB = 8;

    function automatic logic [31:0] caps_word(input logic [7:0] version,
                                              input logic       uptime_en);
        logic [31:0] w;
        w                          = '0;
        w[CAPS_UPTIME_BIT]         = uptime_en;
        w[CAPS_VERSION_LSB +: 8]   = version;
        return w;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/demo_sysid_uptime.sv
// Free-running uptime: 16-bit prescaler feeding a 64-bit counter that advances
// once every TICK_DIV clocks and wraps silently; synchronous clear of both.
module demo_sysid_uptime
    import demo_sysid_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    output logic [63:0] count
);

    localparam logic [15:0] PRESCALE_LAST = 16'(TICK_DIV - 1);

    logic [15:0] prescaler;
    logic        tick;

    assign tick = (prescaler == PRESCALE_LAST);

    // A clear takes priority over a coincident tick so the counter lands on 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            count     <= '0;
        end else if (clear) begin
            prescaler <= '0;
            count     <= '0;
        end else if (tick) begin
            prescaler <= '0;
            count     <= count + 64'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

endmodule

// File: rtl/demo_sysid_regs.sv
// System-ID register block with fixed one-cycle read latency.
// Optional uptime counter, UPTIME_HI shadow and CTRL clear under DEMO_SYSID_UPTIME_EN.
module demo_sysid_regs
    import demo_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0013_8202,
    parameter logic [31:0] TIMESTAMP = 32'h5037_0A25,
    parameter logic [7:0]  VERSION   = 8'h02,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_tick_div_range
        $error("demo_sysid_regs: TICK_DIV must be in 1..65535");
    end

    logic [31:0] scratch;
    logic [31:0] rd_mux;

`ifdef DEMO_SYSID_UPTIME_EN
    localparam logic [31:0] CAPS_VALUE = caps_word(VERSION, 1'b1);

    logic [63:0] uptime_count;
    logic [31:0] uptime_hi_shadow;
    logic        ctrl_clear;

    assign ctrl_clear = write && (address == ADDR_CTRL) && byteenable[0] && writedata[0];

    demo_sysid_uptime #(
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (ctrl_clear),
        .count   (uptime_count)
    );

    // Snapshot uses the counter value before this edge's clear/increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_hi_shadow <= '0;
        end else if (read && (address == ADDR_UPTIME_LO)) begin
            uptime_hi_shadow <= uptime_count[63:32];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_CAPS:      rd_mux = CAPS_VALUE;
            ADDR_UPTIME_LO: rd_mux = uptime_count[31:0];
            ADDR_UPTIME_HI: rd_mux = uptime_hi_shadow;
            ADDR_CTRL:      rd_mux = '0;
            ADDR_RSVD:      rd_mux = '0;
            default:        rd_mux = '0;
        endcase
    end
`else
    localparam logic [31:0] CAPS_VALUE = caps_word(VERSION, 1'b0);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_CAPS:      rd_mux = CAPS_VALUE;
            ADDR_UPTIME_LO,
            ADDR_UPTIME_HI,
            ADDR_CTRL,
            ADDR_RSVD:      rd_mux = '0;
            default:        rd_mux = '0;
        endcase
    end
`endif

    // rd_mux sees SCRATCH before this edge's write, giving read-before-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            scratch       <= '0;
        end else begin
            readdatavalid <= read;
            readdata      <= read ? rd_mux : '0;
            if (write && (address == ADDR_SCRATCH)) begin
                scratch <= byte_merge(scratch, writedata, byteenable);
            end
        end
    end

endmodule
